// File: rtl/ip_hdr_pkg.sv
// Shared types and constants for the IPv4 header checker and generator.
// FSM state encoding, checksum target and hdr_err bit positions.
package ip_hdr_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ACCUM,
    FOLD1,
    FOLD2,
    DONE
  } state_t;

  localparam logic [3:0]  IPV4_VERSION = 4'd4;
  localparam logic [15:0] CSUM_GOOD    = 16'hFFFF;

  localparam int ERR_BAD_VERSION = 2;
  localparam int ERR_BAD_IHL     = 1;
  localparam int ERR_BAD_CSUM    = 0;

endpackage

// File: rtl/ones_comp_fold.sv
// Two-stage end-around-carry fold of a 21-bit ones-complement sum to 16 bits.
// Latency 2 cycles, free-running, no backpressure.
module ones_comp_fold (
  input  logic        clk,
  input  logic        reset,
  input  logic [20:0] din,
  output logic [15:0] dout
);

  logic [16:0] s1;

  // Stage 1 can carry out at most once, so stage 2 never carries again.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1   <= '0;
      dout <= '0;
    end else begin
      s1   <= {1'b0, din[15:0]} + {12'b0, din[20:16]};
      dout <= s1[15:0] + {15'b0, s1[16]};
    end
  end

endmodule

// File: rtl/ipv4_hdr_checker.sv
// Streams 16-bit IPv4 header words, checks version, IHL and checksum.
// Result pulses on done 3 cycles after the last word; in_ready drops while folding.
module ipv4_hdr_checker
  import ip_hdr_pkg::*;
#(
  parameter int CHECK_VERSION = 1,
  parameter int MIN_IHL       = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic        in_sop,
  input  logic [15:0] in_data,
  output logic        in_ready,
  output logic        done,
  output logic        hdr_ok,
  output logic [2:0]  hdr_err,
  output logic        busy
);

  localparam logic [3:0] MIN_IHL_V = 4'(MIN_IHL);

  state_t      state;
  logic [20:0] acc;
  logic [20:0] acc_nxt;
  logic [4:0]  count;
  logic [4:0]  count_inc;
  logic [4:0]  target;
  logic [3:0]  version;
  logic [3:0]  ihl;
  logic [15:0] s2;
  logic        accept;
  logic        bad_version;
  logic        bad_ihl;
  logic        bad_csum;

  assign in_ready  = !reset && (state == IDLE || state == ACCUM);
  assign busy      = (state != IDLE);
  assign accept    = in_valid && in_ready;
  assign count_inc = count + 5'd1;
  assign target    = {ihl, 1'b0};

  assign bad_version = (CHECK_VERSION != 0) && (version != IPV4_VERSION);
  assign bad_ihl     = (ihl < MIN_IHL_V);
  assign bad_csum    = (s2 != CSUM_GOOD);

  // The fold runs on the next accumulator value so s1 is ready in FOLD1
  // and s2 in FOLD2, keeping done at last word + 3.
  always_comb begin
    acc_nxt = acc;
    if (accept && in_sop)
      acc_nxt = {5'b0, in_data};
    else if (accept && state == ACCUM)
      acc_nxt = acc + {5'b0, in_data};
  end

  ones_comp_fold u_fold (
    .clk   (clk),
    .reset (reset),
    .din   (acc_nxt),
    .dout  (s2)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      acc     <= '0;
      count   <= '0;
      version <= '0;
      ihl     <= '0;
      done    <= 1'b0;
      hdr_ok  <= 1'b0;
      hdr_err <= '0;
    end else begin
      acc  <= acc_nxt;
      done <= 1'b0;
      case (state)
        IDLE, ACCUM: begin
          if (accept) begin
            if (in_sop) begin
              version <= in_data[15:12];
              ihl     <= in_data[11:8];
              count   <= 5'd1;
              state   <= (in_data[11:8] < MIN_IHL_V) ? FOLD1 : ACCUM;
            end else if (state == ACCUM) begin
              count <= count_inc;
              if (count_inc == target)
                state <= FOLD1;
            end
          end
        end
        FOLD1: state <= FOLD2;
        FOLD2: begin
          state                    <= DONE;
          done                     <= 1'b1;
          hdr_err[ERR_BAD_VERSION] <= bad_version;
          hdr_err[ERR_BAD_IHL]     <= bad_ihl;
          hdr_err[ERR_BAD_CSUM]    <= bad_csum;
          hdr_ok                   <= !(bad_version || bad_ihl || bad_csum);
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ipv4_hdr_checker.sv
// Self-checking bench: directed header scenarios plus randomized headers
// compared against a plain-arithmetic ones-complement model.
module tb_ipv4_hdr_checker;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_sop;
  logic [15:0] in_data;
  logic        in_ready, done, hdr_ok, busy;
  logic [2:0]  hdr_err;
  logic        nv_ready, nv_done, nv_ok, nv_busy;
  logic [2:0]  nv_err;

  int vectors    = 0;
  int miscompares = 0;
  int done_cnt   = 0;
  logic [15:0] cur[$];

  always #5 clk = ~clk;

  ipv4_hdr_checker dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_sop(in_sop), .in_data(in_data),
    .in_ready(in_ready), .done(done), .hdr_ok(hdr_ok), .hdr_err(hdr_err), .busy(busy)
  );

  ipv4_hdr_checker #(.CHECK_VERSION(0)) dut_nv (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_sop(in_sop), .in_data(in_data),
    .in_ready(nv_ready), .done(nv_done), .hdr_ok(nv_ok), .hdr_err(nv_err), .busy(nv_busy)
  );

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_ref();
    cur = '{16'h4500, 16'h0073, 16'h0000, 16'h4000, 16'h4011,
            16'hB861, 16'hC0A8, 16'h0001, 16'hC0A8, 16'h00C7};
  endtask

  // Rewrites word 5 so the header sums to FFFF in ones-complement.
  task automatic set_csum();
    int ihl = int'(cur[0][11:8]);
    int unsigned s = 0;
    cur[5] = 16'h0000;
    for (int i = 0; i < ihl * 2; i++) s += 32'(cur[i]);
    while (s > 32'hFFFF) s = (s & 32'hFFFF) + (s >> 16);
    cur[5] = ~s[15:0];
  endtask

  // Returns {hdr_ok, bad_version, bad_ihl, bad_checksum} for the header in cur.
  function automatic logic [3:0] model(input bit chk_ver);
    int ver = int'(cur[0][15:12]);
    int ihl = int'(cur[0][11:8]);
    int n = (ihl < 5) ? 1 : ihl * 2;
    int unsigned s = 0;
    logic bc, bi, bv;
    for (int i = 0; i < n; i++) s += 32'(cur[i]);
    while (s > 32'hFFFF) s = (s & 32'hFFFF) + (s >> 16);
    bc = (s != 32'hFFFF);
    bi = (ihl < 5);
    bv = chk_ver && (ver != 4);
    return {!(bc || bi || bv), bv, bi, bc};
  endfunction

  // Leaves the bench in the cycle after the last word was accepted.
  task automatic drive_words(input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        while ($urandom_range(0, 3) == 0) begin
          in_valid = 1'b0;
          in_sop   = 1'($urandom);
          in_data  = 16'($urandom);
          tick();
        end
      end
      in_valid = 1'b1;
      in_sop   = (i == 0);
      in_data  = cur[i];
      tick();
    end
    in_valid = 1'b0;
    in_sop   = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; in_sop = 1'b0; in_data = '0;
    tick(); tick();
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b want 0", done); end
    vectors++; if (hdr_ok !== 1'b0) begin miscompares++; $display("FAIL reset_hdr_ok: got %b want 0", hdr_ok); end
    vectors++; if (hdr_err !== 3'b000) begin miscompares++; $display("FAIL reset_hdr_err: got %b want 000", hdr_err); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
    reset = 1'b0;
    #1;
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL post_reset_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_valid_and_corrupt();
    for (int v = 0; v < 2; v++) begin
      int start = done_cnt;
      logic       want_ok  = (v == 0);
      logic [2:0] want_err = (v == 0) ? 3'b000 : 3'b001;
      load_ref();
      if (v == 1) cur[5] = 16'hB862;
      drive_words(10, 1'b0);
      vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL hdr%0d_done_n1: got %b want 0", v, done); end
      tick();
      vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL hdr%0d_done_n2: got %b want 0", v, done); end
      tick();
      vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL hdr%0d_done_n3: got %b want 1", v, done); end
      vectors++; if (hdr_ok !== want_ok) begin miscompares++; $display("FAIL hdr%0d_ok: got %b want %b", v, hdr_ok, want_ok); end
      vectors++; if (hdr_err !== want_err) begin miscompares++; $display("FAIL hdr%0d_err: got %b want %b", v, hdr_err, want_err); end
      tick();
      vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL hdr%0d_ready_n4: got %b want 1", v, in_ready); end
      vectors++; if (hdr_ok !== want_ok) begin miscompares++; $display("FAIL hdr%0d_ok_hold: got %b want %b", v, hdr_ok, want_ok); end
      vectors++; if (done_cnt !== start + 1) begin miscompares++; $display("FAIL hdr%0d_pulses: got %0d want %0d", v, done_cnt - start, 1); end
    end
  endtask

  task automatic test_short();
    cur = '{16'h4300};
    drive_words(1, 1'b0);
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL short_ready_n1: got %b want 0", in_ready); end
    tick(); tick();
    vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL short_done_n3: got %b want 1", done); end
    vectors++; if (hdr_ok !== 1'b0) begin miscompares++; $display("FAIL short_ok: got %b want 0", hdr_ok); end
    vectors++; if (hdr_err !== 3'b011) begin miscompares++; $display("FAIL short_err: got %b want 011", hdr_err); end
    tick();
  endtask

  task automatic test_version();
    load_ref();
    cur[0] = 16'h6500;
    set_csum();
    drive_words(10, 1'b0);
    tick(); tick();
    vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL ver_done: got %b want 1", done); end
    vectors++; if (hdr_err !== 3'b100) begin miscompares++; $display("FAIL ver_err: got %b want 100", hdr_err); end
    vectors++; if (hdr_ok !== 1'b0) begin miscompares++; $display("FAIL ver_ok: got %b want 0", hdr_ok); end
    vectors++; if (nv_done !== 1'b1) begin miscompares++; $display("FAIL ver_nocheck_done: got %b want 1", nv_done); end
    vectors++; if (nv_ok !== 1'b1) begin miscompares++; $display("FAIL ver_nocheck_ok: got %b want 1", nv_ok); end
    vectors++; if (nv_err !== 3'b000) begin miscompares++; $display("FAIL ver_nocheck_err: got %b want 000", nv_err); end
    tick();
  endtask

  task automatic test_resop();
    int start = done_cnt;
    load_ref();
    drive_words(3, 1'b0);
    drive_words(10, 1'b0);
    tick(); tick();
    vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL resop_done: got %b want 1", done); end
    vectors++; if (hdr_ok !== 1'b1) begin miscompares++; $display("FAIL resop_ok: got %b want 1", hdr_ok); end
    tick();
    vectors++; if (done_cnt !== start + 1) begin miscompares++; $display("FAIL resop_pulses: got %0d want 1", done_cnt - start); end
  endtask

  task automatic test_reset_mid();
    int start = done_cnt;
    load_ref();
    drive_words(5, 1'b0);
    reset = 1'b1; in_valid = 1'b1; in_sop = 1'b0; in_data = cur[5];
    tick();
    reset = 1'b0; in_valid = 1'b0;
    #1;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    vectors++; if (hdr_ok !== 1'b0) begin miscompares++; $display("FAIL rstmid_ok: got %b want 0", hdr_ok); end
    vectors++; if (hdr_err !== 3'b000) begin miscompares++; $display("FAIL rstmid_err: got %b want 000", hdr_err); end
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL rstmid_ready: got %b want 1", in_ready); end
    for (int i = 0; i < 6; i++) tick();
    vectors++; if (done_cnt !== start) begin miscompares++; $display("FAIL rstmid_pulses: got %0d want 0", done_cnt - start); end
  endtask

  task automatic test_back_to_back();
    load_ref();
    drive_words(10, 1'b0);
    in_valid = 1'b1; in_sop = 1'b1; in_data = cur[0];
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL b2b_ready_fold1: got %b want 0", in_ready); end
    tick(); tick();
    vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL b2b_first_done: got %b want 1", done); end
    tick();
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL b2b_dropped_busy: got %b want 0", busy); end
    drive_words(10, 1'b0);
    tick(); tick();
    vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL b2b_second_done: got %b want 1", done); end
    vectors++; if (hdr_ok !== 1'b1) begin miscompares++; $display("FAIL b2b_second_ok: got %b want 1", hdr_ok); end
    tick();
  endtask

  task automatic test_max_len();
    cur.delete();
    for (int i = 0; i < 30; i++) cur.push_back(16'hFFFF);
    drive_words(30, 1'b0);
    tick(); tick();
    vectors++; if (nv_ok !== 1'b1) begin miscompares++; $display("FAIL max_ffff_nocheck_ok: got %b want 1", nv_ok); end
    vectors++; if (hdr_err !== 3'b100) begin miscompares++; $display("FAIL max_ffff_err: got %b want 100", hdr_err); end
    tick();
    cur[0] = 16'h4F00;
    set_csum();
    drive_words(30, 1'b0);
    tick(); tick();
    vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL max_4f_done: got %b want 1", done); end
    vectors++; if (hdr_ok !== 1'b1) begin miscompares++; $display("FAIL max_4f_ok: got %b want 1", hdr_ok); end
    tick();
  endtask

  task automatic test_random();
    for (int k = 0; k < 25; k++) begin
      int ihl = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 4)) : int'($urandom_range(5, 15));
      int ver = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : 4;
      int n = (ihl < 5) ? 1 : ihl * 2;
      logic [3:0] exp_c, exp_n;
      cur.delete();
      cur.push_back({4'(ver), 4'(ihl), 8'($urandom)});
      for (int i = 1; i < n; i++) cur.push_back(16'($urandom));
      if (n > 1 && $urandom_range(0, 3) != 0) set_csum();
      exp_c = model(1'b1);
      exp_n = model(1'b0);
      drive_words(n, 1'b1);
      tick(); tick();
      vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL rnd%0d_done: got %b want 1", k, done); end
      vectors++; if ({hdr_ok, hdr_err} !== exp_c) begin miscompares++; $display("FAIL rnd%0d_result: got %b want %b", k, {hdr_ok, hdr_err}, exp_c); end
      vectors++; if ({nv_ok, nv_err} !== exp_n) begin miscompares++; $display("FAIL rnd%0d_nocheck_result: got %b want %b", k, {nv_ok, nv_err}, exp_n); end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_valid_and_corrupt();
    test_short();
    test_version();
    test_resop();
    test_reset_mid();
    test_back_to_back();
    test_max_len();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ipv4_hdr_checker.md
IPV4_HDR_CHECKER -- requirements
Module: ipv4_hdr_checker

Interface
REQ-001 Parameter CHECK_VERSION, default 1: when 1, a version nibble other than 4 flags a header error.
REQ-002 Parameter MIN_IHL, default 5: the smallest legal IHL value, counted in 32-bit words.
REQ-003 Port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 Port in_valid, input, 1 bit: in_data carries a header word this cycle.
REQ-006 Port in_sop, input, 1 bit: marks the first word of a header (version/IHL/TOS); it is qualified by in_valid.
REQ-007 Port in_data, input, 16 bits: header word in network order, most significant byte first.
REQ-008 Port in_ready, output, 1 bit: the block can accept a word this cycle.
REQ-009 Port done, output, 1 bit: one-cycle pulse that qualifies hdr_ok and hdr_err.
REQ-010 Port hdr_ok, output, 1 bit: the checksum is good and the header is legal; it holds its value until the next done pulse.
REQ-011 Port hdr_err, output, 3 bits: error flags {bad_version, bad_ihl, bad_checksum}; they hold their value until the next done pulse.
REQ-012 Port busy, output, 1 bit: the block is not in IDLE.

Function
REQ-013 A word SHALL be accepted only when in_valid and in_ready are both high; no other word SHALL affect state.
REQ-014 The FSM states SHALL be IDLE, ACCUM, FOLD1, FOLD2 and DONE.
REQ-015 IDLE SHALL hold in_ready=1 and ignore any accepted word that lacks in_sop.
REQ-016 An accepted word with in_sop in IDLE SHALL do all of the following:
- load the accumulator with in_data;
- latch version = in_data[15:12] and ihl = in_data[11:8];
- set the word count to 1;
- move to ACCUM, or to FOLD1 if ihl<MIN_IHL.
REQ-017 The target word count SHALL be ihl*2, an unsigned value of at most 30.
REQ-018 ACCUM SHALL hold in_ready=1 and add each accepted word to a 21-bit accumulator, zero-extended and with no carry wrap during accumulation.
REQ-019 After accepting the word that brings the count to ihl*2, ACCUM SHALL move to FOLD1.
REQ-020 An accepted in_sop word in ACCUM SHALL abandon the current header without a done pulse and restart per REQ-016 in the same cycle.
REQ-021 In FOLD1, s1 (17 bits) SHALL equal acc[15:0]+acc[20:16].
REQ-022 In FOLD2, s2 (16 bits) SHALL equal s1[15:0]+s1[16].
REQ-023 in_ready SHALL be 0 in FOLD1, FOLD2 and DONE, and words offered in those states SHALL be dropped.
REQ-024 On entry to DONE, the block SHALL register the error flags:
- bad_checksum = (s2 != 16'hFFFF);
- bad_ihl = (ihl<MIN_IHL);
- bad_version = CHECK_VERSION && version!=4.
REQ-025 In DONE the block SHALL register hdr_ok = (no flag set) and pulse done=1.
REQ-026 DONE SHALL return to IDLE after exactly one cycle.
REQ-027 If the last header word is accepted at cycle N, done SHALL be high at cycle N+3 and in_ready SHALL be high again at N+4.
REQ-028 When ihl<MIN_IHL, bad_checksum SHALL be computed over the single accepted word, and done SHALL be high at N+3 where N is the in_sop cycle.
REQ-029 An in_sop with in_valid=0 SHALL have no effect.

Reset
REQ-030 Reset SHALL force state IDLE, acc=0, count=0, done=0, hdr_ok=0, hdr_err=3'b000 and busy=0.
REQ-031 in_ready SHALL be 0 in the reset cycle and 1 on the first cycle after reset deasserts.
REQ-032 Reset mid-header SHALL discard the partial header with no done pulse.
REQ-033 Reset SHALL take priority over every other event in the same cycle.

Structure
REQ-034 Package ip_hdr_pkg SHALL hold the state enum, IPV4_VERSION=4, CSUM_GOOD=16'hFFFF, and the hdr_err bit index constants.
REQ-035 The two-stage end-around-carry fold SHALL be sub-module ones_comp_fold, with a 21-bit input, a 16-bit output and one register per stage, so the generator side can reuse it.

Verification
REQ-036 Valid header: reset, then send 4500 0073 0000 4000 4011 B861 C0A8 0001 C0A8 00C7 with sop on the first word -> done at last+3, hdr_ok=1, hdr_err=000.
REQ-037 Corrupt checksum: the same header with B862 in place of B861 -> done, hdr_ok=0, hdr_err=001.
REQ-038 Short header: a single sop word 4300 -> done 3 cycles later, hdr_err bad_ihl=1, hdr_ok=0.
REQ-039 Bad version: 6500 with a correctly recomputed checksum -> hdr_err=100 when CHECK_VERSION=1, and hdr_ok=1 when CHECK_VERSION=0.
REQ-040 Re-sop and reset mid-header:
- sop at word 4, then a full valid header -> exactly one done pulse, hdr_ok=1;
- reset asserted at word 6 -> no done pulse, all outputs at reset values.
REQ-041 Back-to-back and maximum length:
- a second header offered during FOLD1 -> in_ready=0 and the word is dropped; the header resent at N+4 -> hdr_ok=1;
- IHL=15 with 30 words of FFFF and a matching checksum -> no accumulator overflow, hdr_ok=1.
